// File: rtl/fight_match_if.sv
// Signal bundle between the game FSM / combat logic and the fight match controller.
// The master drives game state, ticks and hits; the slave reports the match status.
interface fight_match_if;
  logic [3:0] game_state;
  logic       sec_tick;
  logic       p1_hit;
  logic [6:0] p1_dmg;
  logic       p2_hit;
  logic [6:0] p2_dmg;
  logic [6:0] p1_health;
  logic [6:0] p2_health;
  logic [6:0] round_timer;
  logic [1:0] p1_rounds;
  logic [1:0] p2_rounds;
  logic       round_active;
  logic       game_over;
  logic [1:0] winner;

  modport master (
    output game_state, sec_tick, p1_hit, p1_dmg, p2_hit, p2_dmg,
    input  p1_health, p2_health, round_timer, p1_rounds, p2_rounds,
           round_active, game_over, winner
  );

  modport slave (
    input  game_state, sec_tick, p1_hit, p1_dmg, p2_hit, p2_dmg,
    output p1_health, p2_health, round_timer, p1_rounds, p2_rounds,
           round_active, game_over, winner
  );
endinterface

// File: rtl/fight_match_controller.sv
// Fight-phase match engine: health, round countdown, round wins and match winner.
// Every output comes straight from a flop so the game FSM sees glitch-free status.
module fight_match_controller #(
  parameter int MAX_HEALTH    = 100,
  parameter int ROUND_TIME    = 99,
  parameter int ROUNDS_TO_WIN = 2,
  parameter int KO_PAUSE      = 3
) (
  input  logic clk,
  input  logic reset,
  fight_match_if.slave bus
);

  localparam logic [3:0] FIGHT_STATE = 4'b0010;
  localparam logic [6:0] HEALTH_INIT = 7'(MAX_HEALTH);
  localparam logic [6:0] TIMER_INIT  = 7'(ROUND_TIME);
  localparam logic [1:0] WIN_COUNT   = 2'(ROUNDS_TO_WIN);
  localparam logic [3:0] PAUSE_LAST  = 4'(KO_PAUSE - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ROUND = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t     state_q, state_d;
  logic [6:0] p1_health_q, p1_health_d;
  logic [6:0] p2_health_q, p2_health_d;
  logic [6:0] timer_q, timer_d;
  logic [1:0] p1_rounds_q, p1_rounds_d;
  logic [1:0] p2_rounds_q, p2_rounds_d;
  logic       round_active_q, round_active_d;
  logic       game_over_q, game_over_d;
  logic [1:0] winner_q, winner_d;
  logic [3:0] pause_cnt_q, pause_cnt_d;

  logic       in_fight;
  logic [6:0] p1_hp_new, p2_hp_new, timer_new;
  logic       round_end, p1_scores, p2_scores;
  logic [1:0] p1_rounds_new, p2_rounds_new;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= IDLE;
      p1_health_q    <= HEALTH_INIT;
      p2_health_q    <= HEALTH_INIT;
      timer_q        <= TIMER_INIT;
      p1_rounds_q    <= 2'd0;
      p2_rounds_q    <= 2'd0;
      round_active_q <= 1'b0;
      game_over_q    <= 1'b0;
      winner_q       <= 2'd0;
      pause_cnt_q    <= 4'd0;
    end else begin
      state_q        <= state_d;
      p1_health_q    <= p1_health_d;
      p2_health_q    <= p2_health_d;
      timer_q        <= timer_d;
      p1_rounds_q    <= p1_rounds_d;
      p2_rounds_q    <= p2_rounds_d;
      round_active_q <= round_active_d;
      game_over_q    <= game_over_d;
      winner_q       <= winner_d;
      pause_cnt_q    <= pause_cnt_d;
    end
  end

  // Round-end decision uses this cycle's post-hit, post-tick values so a KO or
  // time-out lands on the same edge as the hit or tick that caused it.
  always_comb begin
    in_fight  = (bus.game_state == FIGHT_STATE);
    p1_hp_new = p1_health_q;
    p2_hp_new = p2_health_q;
    if (bus.p1_hit) p1_hp_new = (bus.p1_dmg >= p1_health_q) ? 7'd0 : p1_health_q - bus.p1_dmg;
    if (bus.p2_hit) p2_hp_new = (bus.p2_dmg >= p2_health_q) ? 7'd0 : p2_health_q - bus.p2_dmg;
    timer_new = (bus.sec_tick && timer_q != 7'd0) ? timer_q - 7'd1 : timer_q;
    round_end = (p1_hp_new == 7'd0) || (p2_hp_new == 7'd0) || (timer_new == 7'd0);
    p1_scores = (p2_hp_new == 7'd0) ||
                (p1_hp_new != 7'd0 && timer_new == 7'd0 && p1_hp_new >= p2_hp_new);
    p2_scores = (p1_hp_new == 7'd0) ||
                (p2_hp_new != 7'd0 && timer_new == 7'd0 && p2_hp_new >= p1_hp_new);
    p1_rounds_new = (p1_scores && p1_rounds_q < WIN_COUNT) ? p1_rounds_q + 2'd1 : p1_rounds_q;
    p2_rounds_new = (p2_scores && p2_rounds_q < WIN_COUNT) ? p2_rounds_q + 2'd1 : p2_rounds_q;
  end

  always_comb begin
    state_d     = state_q;
    p1_health_d = p1_health_q;
    p2_health_d = p2_health_q;
    timer_d     = timer_q;
    p1_rounds_d = p1_rounds_q;
    p2_rounds_d = p2_rounds_q;
    winner_d    = winner_q;
    pause_cnt_d = pause_cnt_q;

    case (state_q)
      IDLE: begin
        if (in_fight) begin
          p1_rounds_d = 2'd0;
          p2_rounds_d = 2'd0;
          winner_d    = 2'd0;
          p1_health_d = HEALTH_INIT;
          p2_health_d = HEALTH_INIT;
          timer_d     = TIMER_INIT;
          state_d     = ROUND;
        end
      end
      ROUND: begin
        if (!in_fight) begin
          state_d = IDLE;
        end else begin
          p1_health_d = p1_hp_new;
          p2_health_d = p2_hp_new;
          timer_d     = timer_new;
          if (round_end) begin
            p1_rounds_d = p1_rounds_new;
            p2_rounds_d = p2_rounds_new;
            pause_cnt_d = 4'd0;
            if (p1_rounds_new == WIN_COUNT || p2_rounds_new == WIN_COUNT) begin
              winner_d = {p2_rounds_new == WIN_COUNT, p1_rounds_new == WIN_COUNT};
              state_d  = DONE;
            end else begin
              state_d = PAUSE;
            end
          end
        end
      end
      PAUSE: begin
        if (!in_fight) begin
          state_d = IDLE;
        end else if (bus.sec_tick) begin
          if (pause_cnt_q == PAUSE_LAST) begin
            p1_health_d = HEALTH_INIT;
            p2_health_d = HEALTH_INIT;
            timer_d     = TIMER_INIT;
            state_d     = ROUND;
          end else begin
            pause_cnt_d = pause_cnt_q + 4'd1;
          end
        end
      end
      DONE: begin
        if (!in_fight) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    round_active_d = (state_d == ROUND);
    game_over_d    = (state_d == DONE);
  end

  assign bus.p1_health    = p1_health_q;
  assign bus.p2_health    = p2_health_q;
  assign bus.round_timer  = timer_q;
  assign bus.p1_rounds    = p1_rounds_q;
  assign bus.p2_rounds    = p2_rounds_q;
  assign bus.round_active = round_active_q;
  assign bus.game_over    = game_over_q;
  assign bus.winner       = winner_q;

endmodule

// File: tb/tb_fight_match_controller.sv
// Directed bench for fight_match_controller: expected output snapshots are queued
// as each cycle's stimulus is driven, then popped and compared after the edge.
module tb_fight_match_controller;

  localparam logic [3:0] FIGHT = 4'b0010;

  typedef struct packed {
    logic [6:0] p1h;
    logic [6:0] p2h;
    logic [6:0] tmr;
    logic [1:0] r1;
    logic [1:0] r2;
    logic       ra;
    logic       go;
    logic [1:0] win;
  } obs_t;

  logic clk;
  logic reset;
  int   checks;
  int   failures;
  obs_t exp_q[$];
  string tag_q[$];

  fight_match_if bus ();

  fight_match_controller #(
    .MAX_HEALTH(100),
    .ROUND_TIME(99),
    .ROUNDS_TO_WIN(2),
    .KO_PAUSE(3)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic obs_t mk(input int p1h, input int p2h, input int tmr, input int r1,
                              input int r2, input int ra, input int go, input int win);
    obs_t o;
    o.p1h = 7'(p1h);
    o.p2h = 7'(p2h);
    o.tmr = 7'(tmr);
    o.r1  = 2'(r1);
    o.r2  = 2'(r2);
    o.ra  = 1'(ra);
    o.go  = 1'(go);
    o.win = 2'(win);
    return o;
  endfunction

  task automatic applyStimulus(input logic [3:0] gs, input logic tick, input logic h1,
                               input int d1, input logic h2, input int d2);
    bus.game_state = gs;
    bus.sec_tick   = tick;
    bus.p1_hit     = h1;
    bus.p1_dmg     = 7'(d1);
    bus.p2_hit     = h2;
    bus.p2_dmg     = 7'(d2);
  endtask

  task automatic checkOutput();
    obs_t  got;
    obs_t  exp;
    string tag;
    exp = exp_q.pop_front();
    tag = tag_q.pop_front();
    got = {bus.p1_health, bus.p2_health, bus.round_timer, bus.p1_rounds, bus.p2_rounds,
           bus.round_active, bus.game_over, bus.winner};
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("[TB] FAIL %s got hp=%0d/%0d t=%0d r=%0d/%0d ra=%0d go=%0d w=%0d expected hp=%0d/%0d t=%0d r=%0d/%0d ra=%0d go=%0d w=%0d",
             tag, got.p1h, got.p2h, got.tmr, got.r1, got.r2, got.ra, got.go, got.win,
             exp.p1h, exp.p2h, exp.tmr, exp.r1, exp.r2, exp.ra, exp.go, exp.win);
    end
  endtask

  // Drive one cycle of stimulus, queue its expected result, compare after the edge.
  task automatic step(input string tag, input logic [3:0] gs, input logic tick, input logic h1,
                      input int d1, input logic h2, input int d2, input obs_t exp);
    applyStimulus(gs, tick, h1, d1, h2, d2);
    exp_q.push_back(exp);
    tag_q.push_back(tag);
    @(posedge clk);
    #1;
    checkOutput();
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    reset    = 1'b1;
    applyStimulus(4'd0, 1'b0, 1'b0, 0, 1'b0, 0);
    #3;
    exp_q.push_back(mk(100, 100, 99, 0, 0, 0, 0, 0));
    tag_q.push_back("reset_values");
    checkOutput();
    #4 reset = 1'b0;

    step("idle_hold", 4'd0, 0, 0, 0, 0, 0, mk(100, 100, 99, 0, 0, 0, 0, 0));
    step("match_start", FIGHT, 0, 0, 0, 0, 0, mk(100, 100, 99, 0, 0, 1, 0, 0));
    step("p2_hit_60", FIGHT, 0, 0, 0, 1, 60, mk(100, 40, 99, 0, 0, 1, 0, 0));
    step("p2_ko", FIGHT, 0, 0, 0, 1, 60, mk(100, 0, 99, 1, 0, 0, 0, 0));
    step("pause_tick1_hit_ignored", FIGHT, 1, 1, 50, 0, 0, mk(100, 0, 99, 1, 0, 0, 0, 0));
    step("pause_tick2", FIGHT, 1, 0, 0, 1, 20, mk(100, 0, 99, 1, 0, 0, 0, 0));
    step("pause_tick3_reload", FIGHT, 1, 0, 0, 0, 0, mk(100, 100, 99, 1, 0, 1, 0, 0));
    step("p2_ko_match_win", FIGHT, 0, 0, 0, 1, 127, mk(100, 0, 99, 2, 0, 0, 1, 1));
    step("done_ignores_hits", FIGHT, 1, 1, 30, 0, 0, mk(100, 0, 99, 2, 0, 0, 1, 1));
    step("end_state_drop", 4'b0011, 0, 0, 0, 0, 0, mk(100, 0, 99, 2, 0, 0, 0, 1));
    step("idle_winner_hold", 4'b0011, 0, 0, 0, 0, 0, mk(100, 0, 99, 2, 0, 0, 0, 1));

    step("dko_start", FIGHT, 0, 0, 0, 0, 0, mk(100, 100, 99, 0, 0, 1, 0, 0));
    step("double_ko", FIGHT, 0, 1, 100, 1, 100, mk(0, 0, 99, 1, 1, 0, 0, 0));
    step("dko_pause1", FIGHT, 1, 0, 0, 0, 0, mk(0, 0, 99, 1, 1, 0, 0, 0));
    step("dko_pause2", FIGHT, 1, 0, 0, 0, 0, mk(0, 0, 99, 1, 1, 0, 0, 0));
    step("dko_pause3", FIGHT, 1, 0, 0, 0, 0, mk(100, 100, 99, 1, 1, 1, 0, 0));
    step("double_ko_draw", FIGHT, 0, 1, 100, 1, 100, mk(0, 0, 99, 2, 2, 0, 1, 3));
    step("draw_leave", 4'd0, 0, 0, 0, 0, 0, mk(0, 0, 99, 2, 2, 0, 0, 3));

    step("tmo_start", FIGHT, 0, 0, 0, 0, 0, mk(100, 100, 99, 0, 0, 1, 0, 0));
    step("tmo_hits", FIGHT, 0, 1, 30, 1, 70, mk(70, 30, 99, 0, 0, 1, 0, 0));
    for (int i = 1; i <= 98; i++)
      step("tmo_countdown", FIGHT, 1, 0, 0, 0, 0, mk(70, 30, 99 - i, 0, 0, 1, 0, 0));
    step("timeout_p1_wins", FIGHT, 1, 0, 0, 0, 0, mk(70, 30, 0, 1, 0, 0, 0, 0));
    step("tmo_pause1_frozen", FIGHT, 1, 0, 0, 0, 0, mk(70, 30, 0, 1, 0, 0, 0, 0));
    step("tmo_pause2_frozen", FIGHT, 1, 0, 0, 0, 0, mk(70, 30, 0, 1, 0, 0, 0, 0));
    step("tmo_pause3_reload", FIGHT, 1, 0, 0, 0, 0, mk(100, 100, 99, 1, 0, 1, 0, 0));
    for (int i = 1; i <= 98; i++)
      step("tmo2_countdown", FIGHT, 1, 0, 0, 0, 0, mk(100, 100, 99 - i, 1, 0, 1, 0, 0));
    step("timeout_equal_hits", FIGHT, 1, 1, 10, 1, 10, mk(90, 90, 0, 2, 1, 0, 1, 1));
    step("done_timer_holds", FIGHT, 1, 0, 0, 0, 0, mk(90, 90, 0, 2, 1, 0, 1, 1));
    step("tmo_leave", 4'd0, 0, 0, 0, 0, 0, mk(90, 90, 0, 2, 1, 0, 0, 1));

    step("sat_start", FIGHT, 0, 0, 0, 0, 0, mk(100, 100, 99, 0, 0, 1, 0, 0));
    step("sat_to_5", FIGHT, 0, 1, 95, 0, 0, mk(5, 100, 99, 0, 0, 1, 0, 0));
    step("sat_127_on_5", FIGHT, 0, 1, 127, 0, 0, mk(0, 100, 99, 0, 1, 0, 0, 0));
    step("sat_pause1", FIGHT, 1, 0, 0, 1, 40, mk(0, 100, 99, 0, 1, 0, 0, 0));
    reset = 1'b1;
    #2;
    exp_q.push_back(mk(100, 100, 99, 0, 0, 0, 0, 0));
    tag_q.push_back("async_reset_pause");
    checkOutput();
    #1 reset = 1'b0;

    step("abort_start", FIGHT, 0, 0, 0, 0, 0, mk(100, 100, 99, 0, 0, 1, 0, 0));
    step("abort_hit", FIGHT, 0, 1, 20, 0, 0, mk(80, 100, 99, 0, 0, 1, 0, 0));
    step("abort_round", 4'd0, 0, 0, 0, 0, 0, mk(80, 100, 99, 0, 0, 0, 0, 0));
    step("abort_idle_hold", 4'd0, 1, 1, 10, 0, 0, mk(80, 100, 99, 0, 0, 0, 0, 0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fight_match_controller.md
# fight_match_controller

Match engine for the fight phase: while the game FSM reports FIGHT_STATE (4'b0010), it tracks both players' health, the per-round countdown and round wins. When one player has won enough rounds, it raises the `game_over` level that moves the game FSM to END_STATE, and it reports the winner for the end screen. Hit events come from the collision/attack logic. Second ticks come from the shared 1 Hz strobe generator.

## Interface
- `MAX_HEALTH`, 100: health loaded at each round start; must fit in 7 bits.
- `ROUND_TIME`, 99: round length in seconds; valid range 1..127.
- `ROUNDS_TO_WIN`, 2: round wins needed to take the match; valid range 1..3.
- `KO_PAUSE`, 3: seconds of pause between rounds; valid range 1..15.

- `clk`  in  1  system clock.
- `reset`  in  1  asynchronous, active-high.
- `game_state`  in  4  current state from the game FSM; 4'b0010 = FIGHT_STATE.
- `sec_tick`  in  1  one-cycle strobe, once per second.
- `p1_hit`  in  1  one-cycle strobe: damage is applied to player 1.
- `p1_dmg`  in  7  damage amount for player 1; valid only with `p1_hit`.
- `p2_hit`  in  1  one-cycle strobe: damage is applied to player 2.
- `p2_dmg`  in  7  damage amount for player 2; valid only with `p2_hit`.
- `p1_health`  out  7  player 1 health.
- `p2_health`  out  7  player 2 health.
- `round_timer`  out  7  seconds remaining in the current round.
- `p1_rounds`  out  2  round wins for player 1.
- `p2_rounds`  out  2  round wins for player 2.
- `round_active`  out  1  high in ROUND state only.
- `game_over`  out  1  level; high in DONE state only.
- `winner`  out  2  00 none, 01 player 1, 10 player 2, 11 draw.

## Operation
- All outputs are registered.
- Reset values: both healths = `MAX_HEALTH`; `round_timer` = `ROUND_TIME`; round counts 0; `round_active`, `game_over`, `winner` all 0; state IDLE.
- **IDLE**
  - `game_state` == FIGHT → start a match: round counts 0, `winner` 0, healths = `MAX_HEALTH`, timer = `ROUND_TIME`, go to ROUND.
  - Otherwise hold all outputs, including `winner` for END_STATE display.
- **ROUND**
  - On `p1_hit`, `p1_health` takes the saturating subtract of `p1_dmg`, clamped at 0. Player 2 is handled the same way.
  - Both hits in the same cycle are applied together.
  - `sec_tick` decrements the timer.
  - End of round is evaluated on the post-update values of the same cycle. The round ends if either health is 0 or the timer is 0.
  - Round result:
    - Exactly one health is 0: the other player wins the round.
    - Both healths are 0 (double KO): both players score.
    - Timer expiry with both alive: the higher health wins; equal health means both score.
  - Round counts saturate at `ROUNDS_TO_WIN`.
  - If any count reaches `ROUNDS_TO_WIN`, go to DONE. Otherwise go to PAUSE.
- **PAUSE**
  - Hits are ignored and the timer is frozen.
  - Count `KO_PAUSE` `sec_tick` pulses. On the last one, reload healths and timer and go to ROUND.
- **DONE**
  - `game_over` = 1; hits and ticks are ignored.
  - `winner`: 01 or 10 if one player reached `ROUNDS_TO_WIN`, 11 if both reached it on the same round.
- **Abort:** in any non-IDLE state, `game_state` != FIGHT → IDLE on the next edge, `game_over` = 0. On an abort before DONE, `winner` stays 00.

## Timing
- Hit sampled at edge N → new health visible after edge N.
- KO hit at edge N → all of the following take effect at that same edge N:
  - health 0,
  - round count incremented,
  - state change,
  - `game_over`/`round_active` update.
- No extra cycle of latency on any of these.
- `sec_tick` taking the timer from 1 to 0 ends the round at that edge, using health that includes same-cycle hits.
- The timer never wraps below 0.
- `game_over` stays high until `game_state` leaves FIGHT. The game FSM sees it one cycle after DONE entry and moves to END_STATE; `game_over` drops on the following edge.
- Match start occurs one edge after `game_state` becomes FIGHT. `round_active` goes high on that edge.
- Async `reset` mid-round returns all outputs to their reset values immediately.

## Test plan
- Enter FIGHT; `p2_hit` with `p2_dmg` = 60, then 60 → `p2_health` 40, then 0; `p1_rounds` = 1; `round_active` = 0; PAUSE lasts 3 ticks, then both healths are 100 and timer is 99.
- Second P1 KO → `game_over` = 1, `winner` = 01; drive `game_state` = 4'b0011 → `game_over` = 0 next edge, `winner` still 01.
- Simultaneous `p1_hit`/`p2_hit`, each dmg 100 → both healths 0, both round counts +1; repeating it ends the match with `winner` = 11.
- Timer expiry with p1 = 70, p2 = 30 on the `sec_tick` that takes the timer 1→0 → `p1_rounds` +1, timer holds 0. Repeat with equal health → both counts +1.
- Hit with dmg 127 on health 5 → health 0, not wrapped. Hits during PAUSE → health unchanged.
- Abort: `game_state` leaves FIGHT mid-round → IDLE next edge, `game_over` 0, `winner` 00. Async reset mid-PAUSE → all outputs at reset values.
